// File: rtl/load_store_unit_if.sv
// Bundle between the datapath, the load/store unit and the data memory.
//   req_*   : request handshake and fields (datapath -> unit, req_ready back)
//   resp_*  : one-cycle completion with extended load data / misalign flag
//   mem_*   : word-addressed data memory port (combinational read data in)
// Modports: slave = the load/store unit, master = datapath + memory side.
interface load_store_unit_if #(parameter int N = 32);
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [1:0]   req_size;
  logic         req_signed;
  logic [N-1:0] req_addr;
  logic [N-1:0] req_wdata;
  logic         resp_valid;
  logic [N-1:0] resp_rdata;
  logic         resp_misaligned;
  logic         mem_read_enable;
  logic         mem_write_enable;
  logic [N-1:0] mem_address;
  logic [N-1:0] mem_write_data;
  logic [N-1:0] mem_data_in;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
           mem_data_in,
    output req_ready, resp_valid, resp_rdata, resp_misaligned,
           mem_read_enable, mem_write_enable, mem_address, mem_write_data
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
           mem_data_in,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned,
           mem_read_enable, mem_write_enable, mem_address, mem_write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one byte/half/word load or store per handshake,
// issues word-wide reads/writes to a word-addressed data memory (sub-word
// stores by read-modify-write) and returns a one-cycle response.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : load_store_unit_if.slave (request, response, memory port)
module load_store_unit #(
  parameter int N = 32
) (
  input  logic                clk,
  input  logic                reset,
  load_store_unit_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] addr_q, addr_d;
  logic [N-1:0] wdata_q, wdata_d;
  logic [N-1:0] rdata_q, rdata_d;
  logic [1:0]   size_q, size_d;
  logic         signed_q, signed_d;
  logic         write_q, write_d;
  logic         mis_q, mis_d;

  logic         req_misaligned;
  logic [N-1:0] merged_word;
  logic [N-1:0] shifted_word;
  logic [N-1:0] load_value;

  always_comb begin
    unique case (bus.req_size)
      2'b00:   req_misaligned = 1'b0;
      2'b01:   req_misaligned = bus.req_addr[0];
      2'b10:   req_misaligned = |bus.req_addr[1:0];
      default: req_misaligned = 1'b1;
    endcase
  end

  // Lane insert for sub-word stores and lane extract for loads, both
  // working on the word currently presented by memory in READ.
  always_comb begin
    merged_word = bus.mem_data_in;
    if (size_q == 2'b00) begin
      merged_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
    shifted_word = bus.mem_data_in >> {addr_q[1:0], 3'b000};
    unique case (size_q)
      2'b00:   load_value = {{(N-8){signed_q & shifted_word[7]}}, shifted_word[7:0]};
      2'b01:   load_value = {{(N-16){signed_q & shifted_word[15]}}, shifted_word[15:0]};
      default: load_value = shifted_word;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    size_d   = size_q;
    signed_d = signed_q;
    write_d  = write_q;
    mis_d    = mis_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d   = bus.req_addr;
          size_d   = bus.req_size;
          signed_d = bus.req_signed;
          write_d  = bus.req_write;
          wdata_d  = bus.req_wdata;
          if (req_misaligned) begin
            mis_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end else if (bus.req_write && bus.req_size == 2'b10) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        // Memory data is only trusted on this edge; a sub-word store keeps
        // the merged word in the write-data register for the WRITE cycle.
        if (write_q) begin
          wdata_d = merged_word;
          state_d = WRITE;
        end else begin
          rdata_d = load_value;
          state_d = RESP;
        end
      end
      WRITE: state_d = RESP;
      RESP: begin
        rdata_d = '0;
        mis_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      write_q  <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      write_q  <= write_d;
      mis_q    <= mis_d;
    end
  end

  always_comb begin
    bus.req_ready        = (state_q == IDLE);
    bus.resp_valid       = (state_q == RESP);
    bus.resp_rdata       = rdata_q;
    bus.resp_misaligned  = mis_q;
    bus.mem_read_enable  = (state_q == READ);
    // Gated by reset so an aborted store cannot touch memory.
    bus.mem_write_enable = (state_q == WRITE) & ~reset;
    bus.mem_address      = ((state_q == READ) || (state_q == WRITE))
                           ? {2'b00, addr_q[N-1:2]} : '0;
    bus.mem_write_data   = (state_q == WRITE) ? wdata_q : '0;
  end

endmodule
